// File: rtl/dm_ext.sv
// Parametrised byte/half/word data memory with sign/zero-extended loads,
// lane-merging stores, error flags and a committed-store counter.
// Optional store log enabled by defining DM_STORE_LOG_EN.
`timescale 1ns/1ps

module dm_ext #(
   parameter int unsigned ADDR_W    = 12,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        WE,
   input  logic [2:0]  op,
   input  logic [31:0] adress,
   input  logic [31:0] Wdata,
   output logic [31:0] Rdata,
   output logic        align_err,
   output logic        range_err,
   output logic [31:0] store_cnt
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   // Byte span of the memory, widened so the comparison cannot overflow.
   localparam logic [33:0] SPAN = 34'(DEPTH) << 2;

   typedef enum logic [1:0] {
      sz_word,
      sz_half,
      sz_byte
   } size_e;

   logic [31:0]       mem [DEPTH];
   logic [31:0]       store_cnt_q;

   size_e             size;
   logic              sext;
   logic [31:0]       off;
   logic [ADDR_W-1:0] idx;
   logic [1:0]        lane;
   logic [31:0]       rword;
   logic [15:0]       half_sel;
   logic [7:0]        byte_sel;
   logic [31:0]       merged;
   logic              commit;

   // Access decode; reserved encodings behave as word accesses.
   always_comb begin
      size = sz_word;
      sext = 1'b0;
      case (op)
         3'b001: size = sz_half;
         3'b010: begin
            size = sz_half;
            sext = 1'b1;
         end
         3'b011: size = sz_byte;
         3'b100: begin
            size = sz_byte;
            sext = 1'b1;
         end
         default: size = sz_word;
      endcase
   end

   assign off       = adress - BASE_ADDR;
   assign idx       = off[ADDR_W+1:2];
   assign lane      = off[1:0];
   assign range_err = (adress < BASE_ADDR) || ({2'b00, off} >= SPAN);

   always_comb begin
      align_err = 1'b0;
      case (size)
         sz_word: align_err = (lane != 2'b00);
         sz_half: align_err = lane[0];
         default: align_err = 1'b0;
      endcase
   end

   assign rword    = mem[idx];
   assign half_sel = lane[1] ? rword[31:16] : rword[15:0];

   always_comb begin
      byte_sel = rword[7:0];
      case (lane)
         2'd1:    byte_sel = rword[15:8];
         2'd2:    byte_sel = rword[23:16];
         2'd3:    byte_sel = rword[31:24];
         default: byte_sel = rword[7:0];
      endcase
   end

   // Load path: errored accesses never expose memory contents.
   always_comb begin
      Rdata = 32'h0;
      if (!align_err && !range_err) begin
         case (size)
            sz_half: Rdata = {{16{sext & half_sel[15]}}, half_sel};
            sz_byte: Rdata = {{24{sext & byte_sel[7]}}, byte_sel};
            default: Rdata = rword;
         endcase
      end
   end

   // Store merge: untouched lanes keep their current contents.
   always_comb begin
      merged = rword;
      case (size)
         sz_half: begin
            if (lane[1]) merged[31:16] = Wdata[15:0];
            else         merged[15:0]  = Wdata[15:0];
         end
         sz_byte: begin
            case (lane)
               2'd1:    merged[15:8]  = Wdata[7:0];
               2'd2:    merged[23:16] = Wdata[7:0];
               2'd3:    merged[31:24] = Wdata[7:0];
               default: merged[7:0]   = Wdata[7:0];
            endcase
         end
         default: merged = Wdata;
      endcase
   end

   assign commit = WE && !align_err && !range_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= 32'h0;
         end
      end else if (commit) begin
         mem[idx] <= merged;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         store_cnt_q <= 32'h0;
      end else if (commit) begin
         store_cnt_q <= store_cnt_q + 32'd1;
      end
   end

   assign store_cnt = store_cnt_q;

`ifdef DM_STORE_LOG_EN
   always_ff @(posedge clk) begin
      if (rst && commit) begin
         $display("%d@%h: *%h <= %h", $time, pc, BASE_ADDR + (32'(idx) << 2), merged);
      end
   end
`else
   // pc only feeds the store log.
   logic unused_pc;
   assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_dm_ext.sv
// Directed self-checking bench for dm_ext: default instance plus a small
// instance with a non-zero base for range checks.
`timescale 1ns/1ps

module tb_dm_ext;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic        we;
   logic        we_r;
   logic [2:0]  op;
   logic [31:0] adress;
   logic [31:0] wdata;
   logic [31:0] rdata,  rdata_r;
   logic        aerr,   aerr_r;
   logic        rerr,   rerr_r;
   logic [31:0] cnt,    cnt_r;

   int ntests = 0;
   int nfail  = 0;

   dm_ext u_dut (
      .clk       (clk),
      .rst       (rst),
      .pc        (pc),
      .WE        (we),
      .op        (op),
      .adress    (adress),
      .Wdata     (wdata),
      .Rdata     (rdata),
      .align_err (aerr),
      .range_err (rerr),
      .store_cnt (cnt)
   );

   dm_ext #(
      .ADDR_W    (4),
      .BASE_ADDR (32'h0000_1000)
   ) u_rng (
      .clk       (clk),
      .rst       (rst),
      .pc        (pc),
      .WE        (we_r),
      .op        (op),
      .adress    (adress),
      .Wdata     (wdata),
      .Rdata     (rdata_r),
      .align_err (aerr_r),
      .range_err (rerr_r),
      .store_cnt (cnt_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set(input logic w, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] d);
      we     = w;
      op     = o;
      adress = a;
      wdata  = d;
      #1;
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
      we   = 1'b0;
      we_r = 1'b0;
      #1;
   endtask

   initial begin
      rst  = 1'b0;
      pc   = 32'h0040_3000;
      we   = 1'b0;
      we_r = 1'b0;
      op   = 3'b000;
      adress = 32'h10;
      wdata  = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("cnt_in_reset", cnt, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("reset_word_load", rdata, 32'h0);
      chk("reset_cnt", cnt, 32'h0);

      // word store, pre-edge value then merged value
      set(1'b1, 3'b000, 32'h4, 32'h1234_5678);
      chk("sw_pre_edge", rdata, 32'h0);
      edge1();
      chk("sw_load", rdata, 32'h1234_5678);
      chk("sw_cnt", cnt, 32'd1);

      // byte store with signed op (sign ignored on stores)
      set(1'b1, 3'b100, 32'h5, 32'hFFFF_FF80);
      edge1();
      set(1'b0, 3'b000, 32'h4, 32'h0);
      chk("sb_merge", rdata, 32'h1234_8078);
      chk("sb_cnt", cnt, 32'd2);
      set(1'b0, 3'b100, 32'h5, 32'h0);
      chk("lb_5", rdata, 32'hFFFF_FF80);
      set(1'b0, 3'b011, 32'h5, 32'h0);
      chk("lbu_5", rdata, 32'h0000_0080);
      set(1'b0, 3'b100, 32'h7, 32'h0);
      chk("lb_7", rdata, 32'h0000_0012);
      set(1'b0, 3'b011, 32'h6, 32'h0);
      chk("lbu_6", rdata, 32'h0000_0034);
      set(1'b0, 3'b010, 32'h4, 32'h0);
      chk("lh_4", rdata, 32'hFFFF_8078);
      set(1'b0, 3'b001, 32'h4, 32'h0);
      chk("lhu_4", rdata, 32'h0000_8078);
      set(1'b0, 3'b111, 32'h4, 32'h0);
      chk("reserved_op_word", rdata, 32'h1234_8078);
      set(1'b0, 3'b110, 32'h5, 32'h0);
      chk("reserved_op_align", {31'h0, aerr}, 32'd1);

      // half store into upper lane
      set(1'b1, 3'b001, 32'hA, 32'hAAAA_BEEF);
      edge1();
      set(1'b0, 3'b000, 32'h8, 32'h0);
      chk("sh_word", rdata, 32'hBEEF_0000);
      set(1'b0, 3'b001, 32'hA, 32'h0);
      chk("lhu_A", rdata, 32'h0000_BEEF);
      set(1'b0, 3'b010, 32'hA, 32'h0);
      chk("lh_A", rdata, 32'hFFFF_BEEF);
      chk("sh_cnt", cnt, 32'd3);

      // misaligned accesses
      set(1'b1, 3'b000, 32'h6, 32'hDEAD_DEAD);
      chk("sw6_align", {31'h0, aerr}, 32'd1);
      chk("sw6_rdata", rdata, 32'h0);
      chk("sw6_range", {31'h0, rerr}, 32'd0);
      edge1();
      set(1'b0, 3'b000, 32'h4, 32'h0);
      chk("sw6_mem_kept", rdata, 32'h1234_8078);
      chk("sw6_cnt_kept", cnt, 32'd3);
      set(1'b0, 3'b010, 32'h5, 32'h0);
      chk("lh5_align", {31'h0, aerr}, 32'd1);
      set(1'b0, 3'b100, 32'h3, 32'h0);
      chk("lb3_no_align", {31'h0, aerr}, 32'd0);

      // range checks on the small instance
      set(1'b0, 3'b000, 32'h1000, 32'h0);
      chk("rng_base_ok", {31'h0, rerr_r}, 32'd0);
      chk("rng_base_load", rdata_r, 32'h0);
      set(1'b0, 3'b000, 32'h1040, 32'hCAFE_0001);
      we_r = 1'b1;
      #1;
      chk("rng_top_err", {31'h0, rerr_r}, 32'd1);
      chk("rng_top_rdata", rdata_r, 32'h0);
      edge1();
      chk("rng_top_cnt", cnt_r, 32'd0);
      set(1'b0, 3'b000, 32'h0FFC, 32'hCAFE_0002);
      we_r = 1'b1;
      #1;
      chk("rng_below_err", {31'h0, rerr_r}, 32'd1);
      edge1();
      chk("rng_below_cnt", cnt_r, 32'd0);
      set(1'b0, 3'b000, 32'h103C, 32'hCAFE_F00D);
      we_r = 1'b1;
      #1;
      chk("rng_last_ok", {31'h0, rerr_r}, 32'd0);
      edge1();
      chk("rng_last_load", rdata_r, 32'hCAFE_F00D);
      chk("rng_last_cnt", cnt_r, 32'd1);
      set(1'b0, 3'b000, 32'h1000, 32'h0);
      chk("rng_no_alias", rdata_r, 32'h0);
      chk("dflt_cnt_after_rng", cnt, 32'd3);

      // reset dropped 1 ns before a store edge
      @(negedge clk);
      set(1'b1, 3'b000, 32'h0, 32'hDEAD_BEEF);
      #3;
      rst = 1'b0;
      #0.5;
      chk("async_cnt_clear", cnt, 32'h0);
      @(posedge clk);
      #1;
      we = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid_word0", rdata, 32'h0);
      chk("rst_mid_cnt", cnt, 32'h0);
      set(1'b0, 3'b000, 32'h4, 32'h0);
      chk("rst_mid_word4", rdata, 32'h0);

      // first edge after release commits
      set(1'b1, 3'b011, 32'h2, 32'h0000_0055);
      edge1();
      set(1'b0, 3'b000, 32'h0, 32'h0);
      chk("post_rst_store", rdata, 32'h0055_0000);
      chk("post_rst_cnt", cnt, 32'd1);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/dm_ext.md
# dm_ext

Parametrised data memory for the single-cycle MIPS datapath, replacing the fixed word-only DM. It adds:
- configurable depth and base address;
- byte, halfword and word access with sign/zero extension on loads;
- read-modify-write byte-lane merging on stores;
- alignment and range error flags;
- a committed-store counter.

Sits between the ALU result (address), the GRF rt read port (store data) and the write-back mux (load data).

## Interface
Parameters:
- ADDR_W, 12, word-index width; DEPTH = 2^ADDR_W words (default 4096 words, 16 KiB)
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- pc  in  32  PC of the instruction issuing the access (store log only)
- WE  in  1  store request this cycle
- op  in  3  access mode: 000 word, 001 half unsigned, 010 half signed, 011 byte unsigned, 100 byte signed; 101–111 reserved, treated as word
- adress  in  32  byte address
- Wdata  in  32  store data; low byte/half used for narrow stores
- Rdata  out  32  load data, extended per op
- align_err  out  1  access misaligned for op
- range_err  out  1  address outside [BASE_ADDR, BASE_ADDR + 4*DEPTH)
- store_cnt  out  32  number of committed stores since reset

## Operation
- Offset and word index:
  - off = adress − BASE_ADDR (32-bit, wrap-around)
  - idx = off[ADDR_W+1:2]; lane = off[1:0]
- range_err = 1 when adress < BASE_ADDR or off ≥ 4*DEPTH.
- align_err:
  - word: lane ≠ 0
  - half: lane[0] ≠ 0
  - byte: never
- Load path (combinational):
  - word: mem[idx]
  - half: mem[idx][16*lane[1] +: 16], zero- or sign-extended per op
  - byte: mem[idx][8*lane +: 8], zero- or sign-extended per op
  - Rdata = 0 whenever align_err or range_err.
- Store path:
  - Commit when WE = 1 and align_err = 0 and range_err = 0.
  - Merge: word replaces all 4 lanes; half replaces lanes {2·lane[1], 2·lane[1]+1} with Wdata[15:0]; byte replaces lane `lane` with Wdata[7:0]; other lanes keep old contents.
  - Sign bit of op is ignored for stores.
  - Errored store: memory and store_cnt unchanged; error flags stay visible for the whole cycle.
- store_cnt increments by 1 per committed store and wraps 0xFFFF_FFFF → 0.

## Timing
- Reset (rst low, asynchronous):
  - all DEPTH words cleared to 0
  - store_cnt = 0
  - Rdata = 0 for any in-range aligned address
  - align_err/range_err remain purely combinational from inputs
- Store latency: 1 edge. A store at edge N is visible on Rdata combinationally immediately after edge N.
- Same-address load and store in one cycle: Rdata shows the pre-store value until the edge, then the merged value.
- rst asserted coincident with a store edge: reset wins; no write, store_cnt = 0.
- rst released: the first edge with rst high may commit a store.

## Configuration
- DM_STORE_LOG_EN defined:
  - every committed store executes `$display("%d@%h: *%h <= %h", $time, pc, BASE_ADDR + 4*idx, merged_word)` at the commit edge
  - the logged value is the full merged word and the word-aligned address
  - errored stores are not logged
- Not defined: no display statements; behaviour otherwise identical.

## Test plan
- Reset then word load: hold rst low 2 cycles, release, op=000 adress=0x0000_0010 → Rdata=0, store_cnt=0.
- Word store/load: WE=1 op=000 adress=0x0000_0004 Wdata=0x1234_5678 → after edge Rdata=0x1234_5678, store_cnt=1; log shows `*00000004 <= 12345678`.
- Byte merge and sign extension:
  - sb 0x80 at adress 0x0000_0005 over 0x1234_5678 → word reads 0x1234_8078.
  - lb at 0x5 → Rdata=0xFFFF_FF80; lbu → 0x0000_0080.
  - lh at 0x4 → 0xFFFF_8078.
- Half store upper lane: sh Wdata=0xAAAA_BEEF at adress 0x0000_000A over 0 → word at 0x8 = 0xBEEF_0000; lhu at 0xA → 0x0000_BEEF.
- Errors:
  - sw at 0x0000_0006 → align_err=1, Rdata=0, memory and store_cnt unchanged.
  - With BASE_ADDR=0x1000, ADDR_W=4, a load/store at 0x1040 or 0x0FFC → range_err=1, no write.
- Reset mid-operation: WE=1 sw 0xDEAD_BEEF at 0x0, drop rst low 1 ns before the edge → after release word 0 reads 0, store_cnt=0.
